// File: rtl/riscv_defines.sv
// riscv_defines: shared register-file geometry used by the writeback path.
`default_nettype none

package riscv_defines;

  localparam int RF_ADDR_WIDTH = 6;
  localparam int RF_DATA_WIDTH = 32;
  localparam int FP_BANK_BIT   = 5;

  // Width of an index able to address n requesters (never zero).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_rr_pick2.sv
// riscv_rr_pick2: combinational rotating scan returning the first two valid requesters.
`default_nettype none

module riscv_rr_pick2
  import riscv_defines::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic            first_vld,
  output logic [PW-1:0]   first_idx,
  output logic            second_vld,
  output logic [PW-1:0]   second_idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    sum        = '0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr < NREQ, so a single subtraction wraps the scan position.
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (valid[idx]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = idx;
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_rf_wb_arbiter.sv
// riscv_rf_wb_arbiter: round-robin arbiter merging NREQ writeback requesters onto
// two registered register-file write ports.
`default_nettype none

module riscv_rf_wb_arbiter
  import riscv_defines::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hold_i,
  input  logic [NREQ-1:0]                  req_valid_i,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NREQ-1:0]                  req_ready_o,
  output logic [ADDR_WIDTH-1:0]            waddr_a_o,
  output logic [DATA_WIDTH-1:0]            wdata_a_o,
  output logic                             we_a_o,
  output logic [ADDR_WIDTH-1:0]            waddr_b_o,
  output logic [DATA_WIDTH-1:0]            wdata_b_o,
  output logic                             we_b_o,
  output logic [1:0]                       grant_cnt_o
);

  localparam int PW = idx_width(NREQ);

  logic [PW-1:0]         rr_ptr;
  logic                  a_vld;
  logic                  b_vld;
  logic [PW-1:0]         a_idx;
  logic [PW-1:0]         b_idx;
  logic [PW-1:0]         last_idx;
  logic [PW-1:0]         rr_next;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  issue;
  logic                  grant_a;
  logic                  grant_b;

  riscv_rr_pick2 #(
    .NREQ(NREQ)
  ) u_pick2 (
    .valid      (req_valid_i),
    .ptr        (rr_ptr),
    .first_vld  (a_vld),
    .first_idx  (a_idx),
    .second_vld (b_vld),
    .second_idx (b_idx)
  );

  // x0 is integer-bank register 0; FP register f0 sits at the FP bank bit and is writable.
  function automatic logic is_x0(input logic [ADDR_WIDTH-1:0] addr);
    return !addr[FP_BANK_BIT] && (addr == '0);
  endfunction

  assign a_addr = req_addr_i[a_idx];
  assign b_addr = req_addr_i[b_idx];

  assign issue   = !hold_i && !rst;
  assign grant_a = issue && a_vld;
  // A same-address second winner is dropped rather than replaced by a later requester.
  assign grant_b = grant_a && b_vld && (b_addr != a_addr);

  always_comb begin
    req_ready_o = '0;
    if (grant_a) begin
      req_ready_o[a_idx] = 1'b1;
    end
    if (grant_b) begin
      req_ready_o[b_idx] = 1'b1;
    end
  end

  assign grant_cnt_o = {1'b0, grant_a} + {1'b0, grant_b};

  assign last_idx = grant_b ? b_idx : a_idx;
  assign rr_next  = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      we_a_o    <= 1'b0;
      we_b_o    <= 1'b0;
      waddr_a_o <= '0;
      waddr_b_o <= '0;
      wdata_a_o <= '0;
      wdata_b_o <= '0;
    end else begin
      we_a_o <= grant_a && !is_x0(a_addr);
      we_b_o <= grant_b && !is_x0(b_addr);
      if (grant_a) begin
        waddr_a_o <= a_addr;
        wdata_a_o <= req_data_i[a_idx];
        rr_ptr    <= rr_next;
      end
      if (grant_b) begin
        waddr_b_o <= b_addr;
        wdata_b_o <= req_data_i[b_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_rf_wb_arbiter.sv
// tb_riscv_rf_wb_arbiter: directed and randomized checks of the writeback arbiter
// against a scan-order reference model.
`default_nettype none

module tb_riscv_rf_wb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    hold;
  logic [NREQ-1:0]         valid;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] data;
  logic [NREQ-1:0]         ready;
  logic [AW-1:0]           waddr_a, waddr_b;
  logic [DW-1:0]           wdata_a, wdata_b;
  logic                    we_a, we_b;
  logic [1:0]              gcnt;

  riscv_rf_wb_arbiter #(
    .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .hold_i(hold),
    .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
    .req_ready_o(ready),
    .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
    .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
    .grant_cnt_o(gcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference state: pointer plus the contents expected on the write ports.
  int          m_rr = 0;
  logic        m_we_a = 1'b0, m_we_b = 1'b0;
  logic [AW-1:0] m_wa_a = '0, m_wa_b = '0;
  logic [DW-1:0] m_wd_a = '0, m_wd_b = '0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // List valid requesters in rotating order, take the first two, drop the second on an address clash.
  function automatic void model_pick(output int ia, output int ib);
    int cand[$];
    ia = -1;
    ib = -1;
    if (!hold && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (valid[j]) cand.push_back(j);
      end
      if (cand.size() > 0) ia = cand[0];
      if (cand.size() > 1 && addr[cand[1]] != addr[cand[0]]) ib = cand[1];
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int ia, ib;
      logic [NREQ-1:0] exp_rdy;
      model_pick(ia, ib);
      exp_rdy = '0;
      if (ia >= 0) exp_rdy[ia] = 1'b1;
      if (ib >= 0) exp_rdy[ib] = 1'b1;
      cmp("ready", 64'(ready), 64'(exp_rdy));
      cmp("grant_cnt", 64'(gcnt), 64'((ia >= 0) + (ib >= 0)));
      cmp("we_a", 64'(we_a), 64'(m_we_a));
      cmp("we_b", 64'(we_b), 64'(m_we_b));
      cmp("waddr_a", 64'(waddr_a), 64'(m_wa_a));
      cmp("waddr_b", 64'(waddr_b), 64'(m_wa_b));
      cmp("wdata_a", 64'(wdata_a), 64'(m_wd_a));
      cmp("wdata_b", 64'(wdata_b), 64'(m_wd_b));
      cmp("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
      if (rst) begin
        m_rr = 0;
        m_we_a = 1'b0; m_we_b = 1'b0;
        m_wa_a = '0; m_wa_b = '0; m_wd_a = '0; m_wd_b = '0;
      end else begin
        m_we_a = (ia >= 0) && (addr[ia] != 0);
        m_we_b = (ib >= 0) && (addr[ib] != 0);
        if (ia >= 0) begin m_wa_a = addr[ia]; m_wd_a = data[ia]; end
        if (ib >= 0) begin m_wa_b = addr[ib]; m_wd_b = data[ib]; end
        if (ia >= 0) m_rr = (((ib >= 0) ? ib : ia) + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_addrs(input int a0, input int a1, input int a2, input int a3);
    addr[0] = AW'(a0); addr[1] = AW'(a1); addr[2] = AW'(a2); addr[3] = AW'(a3);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; valid = '0; addr = '0; data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    mid();
    cmp("lit_reset_ready", 64'(ready), 64'h0);
    cmp("lit_reset_we_a", 64'(we_a), 64'h0);
    cmp("lit_reset_waddr_a", 64'(waddr_a), 64'h0);
    cmp("lit_reset_rr", 64'(dut.rr_ptr), 64'h0);
    tick();

    // Single request on r0.
    rst = 1'b0; valid = 4'b0001; set_addrs(3, 0, 0, 0); data[0] = 32'hAA;
    mid(); cmp("lit_single_ready", 64'(ready), 64'h1);
    tick();
    valid = '0;
    mid();
    cmp("lit_single_we_a", 64'(we_a), 64'h1);
    cmp("lit_single_waddr_a", 64'(waddr_a), 64'h3);
    cmp("lit_single_wdata_a", 64'(wdata_a), 64'hAA);
    cmp("lit_single_we_b", 64'(we_b), 64'h0);
    cmp("lit_single_rr", 64'(dut.rr_ptr), 64'h1);
    tick();

    // All four requesting from rr_ptr=0.
    rst = 1'b1; tick();
    rst = 1'b0; valid = 4'b1111; set_addrs(1, 2, 3, 4);
    for (int i = 0; i < NREQ; i++) data[i] = DW'(32'h100 + i);
    mid(); cmp("lit_four_ready0", 64'(ready), 64'h3);
    tick();
    mid();
    cmp("lit_four_ready1", 64'(ready), 64'hC);
    cmp("lit_four_waddr_a0", 64'(waddr_a), 64'h1);
    cmp("lit_four_waddr_b0", 64'(waddr_b), 64'h2);
    tick();
    valid = '0;
    mid();
    cmp("lit_four_waddr_a1", 64'(waddr_a), 64'h3);
    cmp("lit_four_waddr_b1", 64'(waddr_b), 64'h4);
    cmp("lit_four_rr", 64'(dut.rr_ptr), 64'h0);
    tick();

    // Same destination on r0 and r1.
    valid = 4'b0011; set_addrs(7, 7, 0, 0); data[0] = 32'h11; data[1] = 32'h22;
    mid(); cmp("lit_clash_ready0", 64'(ready), 64'h1);
    tick();
    mid();
    cmp("lit_clash_ready1", 64'(ready), 64'h2);
    cmp("lit_clash_we_b", 64'(we_b), 64'h0);
    cmp("lit_clash_wdata_a0", 64'(wdata_a), 64'h11);
    tick();
    valid = '0;
    mid(); cmp("lit_clash_wdata_a1", 64'(wdata_a), 64'h22);
    tick();

    // Write to x0 is granted but suppressed.
    valid = 4'b0001; set_addrs(0, 0, 0, 0);
    mid(); cmp("lit_x0_ready", 64'(ready), 64'h1);
    tick();
    valid = '0;
    mid(); cmp("lit_x0_we_a", 64'(we_a), 64'h0);
    tick();

    // Hold for three cycles, then release.
    hold = 1'b1; valid = 4'b1111; set_addrs(1, 2, 3, 4);
    for (int c = 0; c < 3; c++) begin
      mid();
      cmp("lit_hold_ready", 64'(ready), 64'h0);
      cmp("lit_hold_rr", 64'(dut.rr_ptr), 64'h1);
      tick();
    end
    hold = 1'b0;
    mid(); cmp("lit_release_ready", 64'(ready), 64'h6);
    tick();

    // Reset in a grant cycle.
    rst = 1'b1;
    mid(); cmp("lit_rstgrant_ready", 64'(ready), 64'h0);
    tick();
    rst = 1'b0; valid = '0;
    mid();
    cmp("lit_rstgrant_we_a", 64'(we_a), 64'h0);
    cmp("lit_rstgrant_we_b", 64'(we_b), 64'h0);
    cmp("lit_rstgrant_rr", 64'(dut.rr_ptr), 64'h0);
    tick();

    // Randomized traffic with small address pool to provoke clashes and x0 writes.
    for (int c = 0; c < 3000; c++) begin
      valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = ($urandom_range(0, 3) == 0) ? AW'(32 + $urandom_range(0, 3)) : AW'($urandom_range(0, 7));
        data[i] = $urandom;
      end
      hold = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; hold = 1'b0; valid = '0;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_rf_wb_arbiter.md
RISCV_RF_WB_ARBITER -- requirements
Module: riscv_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of writeback requesters.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning register address width; bit 5 selects the FP bank.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning write data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port hold_i  input  1  stall; when high, no grants are issued.
REQ-007 SHALL have port req_valid_i  input  NREQ  per-requester write request.
REQ-008 SHALL have port req_addr_i  input  NREQ x ADDR_WIDTH  per-requester destination register.
REQ-009 SHALL have port req_data_i  input  NREQ x DATA_WIDTH  per-requester write data.
REQ-010 SHALL have port req_ready_o  output  NREQ  grant; a request is consumed when valid and ready are both high.
REQ-011 SHALL have ports waddr_a_o / wdata_a_o / we_a_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port A.
REQ-012 SHALL have ports waddr_b_o / wdata_b_o / we_b_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register-file write port B.
REQ-013 SHALL have port grant_cnt_o  output  2  number of grants issued in the current cycle (0..2), for performance counters.

Function
REQ-014 SHALL hold a round-robin pointer rr_ptr, range 0..NREQ-1.
REQ-015 SHALL scan requesters each cycle in order rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-016 SHALL grant the first valid requester in scan order to port A.
REQ-017 SHALL grant the second valid requester in scan order to port B, unless its address equals port A's address.
REQ-018 SHALL, on that address conflict, leave the second requester ungranted; it is not considered for port B further down the scan.
REQ-019 SHALL drive req_ready_o combinationally, high only for granted requesters; at most 2 bits high per cycle.
REQ-020 SHALL register port outputs; a grant in cycle N appears on we/waddr/wdata in cycle N+1 (1-cycle latency).
REQ-021 SHALL grant a request with address 0, but SHALL drive we low for it (write dropped, x0 hardwired).
REQ-022 SHALL drive we_a_o=we_b_o=0 in the following cycle when no grant is issued; waddr/wdata then hold their previous values.
REQ-023 SHALL issue no grants while hold_i=1 (all ready low, rr_ptr unchanged).
REQ-024 SHALL set rr_ptr to (index of last granted requester + 1) mod NREQ on any grant; otherwise rr_ptr is unchanged.
REQ-025 SHALL use port B only if port A is granted; a single grant always uses port A.
REQ-026 SHALL have no combinational path from req_* inputs to we/waddr/wdata outputs.

Reset
REQ-027 SHALL, while rst=1, force rr_ptr=0, we_a_o=we_b_o=0, waddr_*=0, wdata_*=0 and req_ready_o=0.
REQ-028 SHALL discard, on rst asserted mid-operation, any grant of that cycle; the outputs in the next cycle are the reset values.

Structure
REQ-029 SHALL take ADDR_WIDTH/DATA_WIDTH defaults and the FP-bank bit index (5) from the shared riscv_defines package.
REQ-030 SHALL implement the rotating two-winner selection as one sub-module, riscv_rr_pick2, which is combinational and parameterized by NREQ.

Verification
REQ-031 SHALL check: reset, then valid=4'b0001 addr0=3 data0=0xAA -> ready=4'b0001; next cycle we_a=1 waddr_a=3 wdata_a=0xAA, we_b=0; rr_ptr=1.
REQ-032 SHALL check: rr_ptr=0, valid=4'b1111, addrs 1,2,3,4 -> ready=4'b0011, port A=r0 and port B=r1; next cycle ready=4'b1100 with A=r2, B=r3.
REQ-033 SHALL check: valid=4'b0011, both addr=7 -> ready=4'b0001 and we_b stays 0; next cycle r1 is granted on port A.
REQ-034 SHALL check: valid=4'b0001 addr=0 -> ready=4'b0001, we_a=0 next cycle.
REQ-035 SHALL check: hold_i=1 for 3 cycles with valid=4'b1111 -> ready=0, we=0 and rr_ptr constant; release gives the same grants as before the hold.
REQ-036 SHALL check: rst pulsed in the cycle of a grant -> next cycle we_a=we_b=0 and rr_ptr=0.
